// File: rtl/fifo_pop_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_scheduler_pkg
// Purpose  : Shared types and constants for the three-FIFO pop scheduler:
//            FSM state encoding, Out_SRC codes, parameter defaults and a
//            grant-to-source helper.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pop_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] c_SRC_NONE = 2'd0;
  localparam logic [1:0] c_SRC_F1   = 2'd1;
  localparam logic [1:0] c_SRC_F2   = 2'd2;
  localparam logic [1:0] c_SRC_F3   = 2'd3;

  localparam int unsigned c_DEF_RD_LAT    = 1;
  localparam int unsigned c_DEF_BURST_LEN = 4;

  // One-hot grant (bit0 = FIFO1) to the Out_SRC code of that FIFO.
  function automatic logic [1:0] grant_to_src(input logic [2:0] grant);
    logic [1:0] src;
    src = c_SRC_NONE;
    if (grant[0])      src = c_SRC_F1;
    else if (grant[1]) src = c_SRC_F2;
    else if (grant[2]) src = c_SRC_F3;
    return src;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_scheduler_if
// Purpose  : FIFO-side and consumer-side signal bundle of the pop scheduler.
//            master = scheduler, slave = FIFOs plus consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_pop_scheduler_if;
  logic [2:0]  Enable_i;
  logic [3:0]  POP_FLAG1_i;
  logic [3:0]  POP_FLAG2_i;
  logic [3:0]  POP_FLAG3_i;
  logic [7:0]  FIFO1_DOUT_i;
  logic [15:0] FIFO2_DOUT_i;
  logic [31:0] FIFO3_DOUT_i;
  logic        POP1_o;
  logic        POP2_o;
  logic        POP3_o;
  logic [31:0] Out_DAT_o;
  logic [1:0]  Out_SRC_o;
  logic        Out_VLD_o;
  logic        Out_RDY_i;
  logic        Busy_o;

  modport master (
    input  Enable_i, POP_FLAG1_i, POP_FLAG2_i, POP_FLAG3_i,
    input  FIFO1_DOUT_i, FIFO2_DOUT_i, FIFO3_DOUT_i, Out_RDY_i,
    output POP1_o, POP2_o, POP3_o, Out_DAT_o, Out_SRC_o, Out_VLD_o, Busy_o
  );

  modport slave (
    output Enable_i, POP_FLAG1_i, POP_FLAG2_i, POP_FLAG3_i,
    output FIFO1_DOUT_i, FIFO2_DOUT_i, FIFO3_DOUT_i, Out_RDY_i,
    input  POP1_o, POP2_o, POP3_o, Out_DAT_o, Out_SRC_o, Out_VLD_o, Busy_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pop_scheduler_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter3
// Purpose  : Combinational 3-way round-robin pick. Search starts at the FIFO
//            after the last granted one; output is one-hot (bit0 = FIFO1).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter3
  import fifo_pop_scheduler_pkg::*;
(
  input  logic [2:0] i_elig,
  input  logic [1:0] i_last,
  output logic [2:0] o_grant
);

  // Priority rotates with the last grant; an unused last code behaves as FIFO3.
  always_comb begin
    o_grant = 3'b000;
    case (i_last)
      c_SRC_F1: begin
        if (i_elig[1])      o_grant = 3'b010;
        else if (i_elig[2]) o_grant = 3'b100;
        else if (i_elig[0]) o_grant = 3'b001;
      end
      c_SRC_F2: begin
        if (i_elig[2])      o_grant = 3'b100;
        else if (i_elig[0]) o_grant = 3'b001;
        else if (i_elig[1]) o_grant = 3'b010;
      end
      default: begin
        if (i_elig[0])      o_grant = 3'b001;
        else if (i_elig[1]) o_grant = 3'b010;
        else if (i_elig[2]) o_grant = 3'b100;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_scheduler
// Purpose  : Round-robin pop scheduler for three FIFOs. Pops one word, waits
//            RD_LAT cycles for read data, presents it with a valid/ready
//            handshake and keeps bursting up to BURST_LEN words per grant.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pop_scheduler
  import fifo_pop_scheduler_pkg::*;
#(
  parameter int unsigned RD_LAT    = c_DEF_RD_LAT,
  parameter int unsigned BURST_LEN = c_DEF_BURST_LEN
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  fifo_pop_scheduler_if.master bus
);

  localparam logic [1:0] c_RD_LAT    = 2'(RD_LAT);
  localparam logic [3:0] c_BURST_LEN = 4'(BURST_LEN);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_grant;
  logic [1:0]  r_last;
  logic [1:0]  r_lat_cnt;
  logic [3:0]  r_burst;
  logic [31:0] r_dat;
  logic [1:0]  r_src;
  logic        r_vld;

  logic [2:0]  w_elig;
  logic [2:0]  w_arb_grant;
  logic [3:0]  w_burst_inc;
  logic [31:0] w_dout;
  logic        w_load_grant;
  logic        w_capture;
  logic        w_hs_cont;
  logic        w_hs_end;
  logic        w_pop_en;

  assign w_elig = bus.Enable_i & {bus.POP_FLAG3_i != 4'h0,
                                  bus.POP_FLAG2_i != 4'h0,
                                  bus.POP_FLAG1_i != 4'h0};
  assign w_burst_inc = r_burst + 4'd1;

  rr_arbiter3 u_arb (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_grant (w_arb_grant)
  );

  // Zero-extended read data of the currently granted FIFO.
  always_comb begin
    w_dout = bus.FIFO3_DOUT_i;
    case (r_grant)
      3'b001:  w_dout = {24'h0, bus.FIFO1_DOUT_i};
      3'b010:  w_dout = {16'h0, bus.FIFO2_DOUT_i};
      default: w_dout = bus.FIFO3_DOUT_i;
    endcase
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_next_state = r_state;
    w_load_grant = 1'b0;
    w_capture    = 1'b0;
    w_hs_cont    = 1'b0;
    w_hs_end     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_load_grant = 1'b1;
          w_next_state = ST_POP;
        end
      end
      ST_POP: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_lat_cnt == c_RD_LAT) begin
          w_capture    = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.Out_RDY_i) begin
          // Stay on the same FIFO only while the burst has room and it still has data.
          if ((w_burst_inc < c_BURST_LEN) && |(r_grant & w_elig)) begin
            w_hs_cont    = 1'b1;
            w_next_state = ST_POP;
          end else begin
            w_hs_end     = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  // Grant, latency/burst counters and the output word register.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_grant   <= 3'b000;
      r_last    <= c_SRC_F3;
      r_lat_cnt <= 2'd0;
      r_burst   <= 4'd0;
      r_dat     <= 32'h0;
      r_src     <= c_SRC_NONE;
      r_vld     <= 1'b0;
    end else begin
      if (w_load_grant) r_grant <= w_arb_grant;
      // Counter names the WAIT cycle index after the pop (first WAIT cycle = 1).
      if (r_state == ST_POP)                   r_lat_cnt <= 2'd1;
      else if (r_state == ST_WAIT && !w_capture) r_lat_cnt <= r_lat_cnt + 2'd1;
      if (w_capture) begin
        r_dat <= w_dout;
        r_src <= grant_to_src(r_grant);
        r_vld <= 1'b1;
      end
      if (w_hs_cont || w_hs_end) begin
        r_vld <= 1'b0;
        r_src <= c_SRC_NONE;
      end
      if (w_hs_cont) r_burst <= w_burst_inc;
      if (w_hs_end) begin
        r_burst <= 4'd0;
        r_last  <= grant_to_src(r_grant);
      end
    end
  end

  // Reset masks the strobe so an in-flight POP cycle never reaches a FIFO.
  assign w_pop_en      = (r_state == ST_POP) && !WBs_RST_i;
  assign bus.POP1_o    = w_pop_en & r_grant[0];
  assign bus.POP2_o    = w_pop_en & r_grant[1];
  assign bus.POP3_o    = w_pop_en & r_grant[2];
  assign bus.Out_DAT_o = r_dat;
  assign bus.Out_SRC_o = r_src;
  assign bus.Out_VLD_o = r_vld;
  assign bus.Busy_o    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/fifo_pop_scheduler.md
FIFO_POP_SCHEDULER -- requirements
Module: fifo_pop_scheduler

Interface
REQ-001 Parameter RD_LAT, default 1, cycles from a FIFO POP strobe to valid DOUT (legal 1..3).
REQ-002 Parameter BURST_LEN, default 4, max consecutive words taken from one FIFO per grant (legal 1..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 WBs_CLK_i  in  1  sole clock, all state on rising edge.
REQ-005 WBs_RST_i  in  1  synchronous active-high reset.
REQ-006 Enable_i  in  3  per-FIFO service enable, bit0=FIFO1 .. bit2=FIFO3.
REQ-007 POP_FLAG1_i / POP_FLAG2_i / POP_FLAG3_i  in  4 each  FIFO pop-side level code, 4'h0 = empty.
REQ-008 FIFO1_DOUT_i  in  8;  FIFO2_DOUT_i  in  16;  FIFO3_DOUT_i  in  32  FIFO read data.
REQ-009 POP1_o / POP2_o / POP3_o  out  1 each  single-cycle pop strobes to FIFO1..3.
REQ-010 Out_DAT_o  out  32  captured word, zero-extended.
REQ-011 Out_SRC_o  out  2  source of Out_DAT_o: 2'd1..2'd3 = FIFO1..3, 2'd0 = none.
REQ-012 Out_VLD_o  out  1  word valid; Out_RDY_i  in  1  consumer accept.
REQ-013 Busy_o  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, POP, WAIT and HOLD.
REQ-015 Eligible[n] SHALL be Enable_i[n] & (POP_FLAGn != 4'h0), sampled only in IDLE and at a HOLD handshake.
REQ-016 IDLE: if any bit is eligible, grant the first eligible FIFO in round-robin order, starting after the last granted FIFO, then go to POP; otherwise stay in IDLE.
REQ-017 POP: assert the granted POPn_o for exactly one cycle, then go to WAIT.
REQ-018 At most one POPn_o SHALL be high in any cycle, and it SHALL never pulse for a FIFO whose flag was 4'h0 at the decision edge.
REQ-019 WAIT: for a POP in cycle t, capture the zero-extended DOUT at the edge ending cycle t+RD_LAT and set Out_SRC_o; Out_VLD_o rises in cycle t+RD_LAT+1 (state HOLD).
REQ-020 HOLD: Out_DAT_o, Out_SRC_o and Out_VLD_o SHALL stay stable until an edge with Out_RDY_i=1.
REQ-021 On a HOLD handshake: Out_VLD_o drops and the burst count increments.
REQ-022 After that handshake, if count < BURST_LEN and the granted FIFO is still eligible, go directly to POP with no IDLE cycle.
REQ-023 Otherwise record the grant as last-granted, clear the count and go to IDLE.
REQ-024 With RD_LAT=1 and Out_RDY_i tied high, a sustained burst SHALL yield one word per 3 cycles.
REQ-025 Deasserting Enable_i or a flag change mid-operation SHALL NOT abort an issued pop; the word completes and no further pop follows.
REQ-026 Out_SRC_o SHALL be 2'd0 whenever Out_VLD_o=0.

Reset
REQ-027 During reset: state=IDLE, all POPn_o=0, Out_VLD_o=0, Out_DAT_o=0, Out_SRC_o=0, Busy_o=0, burst count=0, last-granted=FIFO3 (so FIFO1 wins first).
REQ-028 Reset asserted in POP, WAIT or HOLD SHALL discard the in-flight word, with no pop issued in the reset cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the Out_SRC codes and the RD_LAT/BURST_LEN defaults.
REQ-030 One sub-module, rr_arbiter3, SHALL hold the combinational 3-way round-robin pick (eligible[2:0], last[1:0] -> grant one-hot).
REQ-031 The WAIT latency counter SHALL be 2 bits and the burst counter 4 bits.

Verification
REQ-032 Reset, then FIFO1 flag 4'h1 with Enable=3'b111, RDY=1, FIFO1_DOUT=8'hA5 -> POP1 pulses 1 cycle, Out_DAT=32'h000000A5 and Out_SRC=1 one cycle after WAIT.
REQ-033 All three FIFOs non-empty, BURST_LEN=1 -> grant order FIFO1, FIFO2, FIFO3, FIFO1, and never two POPs in one cycle.
REQ-034 FIFO3 holds 6 words, BURST_LEN=4, others empty -> 4 back-to-back words (POP every 3 cycles), one IDLE cycle, then 2 more words.
REQ-035 RDY low for 10 cycles in HOLD -> Out_DAT/SRC/VLD unchanged, no POP, then exactly 1 handshake when RDY rises.
REQ-036 Enable_i cleared during WAIT -> captured word is still presented, no further POP; reset during HOLD -> Out_VLD=0 the next cycle and the word is dropped.
REQ-037 RD_LAT=3 -> capture exactly 3 cycles after POP; a DOUT change in the cycle before the capture edge is not taken.
